iq_sat_accum: RTL

//  Parametrised saturating I/Q combiner. Next generation of the DRFM I/Q adder.
//  - Adds runtime ADD/SUB/ACCUMULATE modes, valid qualification and saturation statistics.
//  - Sits after the mixer; feeds the DRFM sample path and the status registers.
//  - Each output is the exact signed result, saturated to the OUT_W signed range.

---
 rtl/iq_sat_accum_if.sv | 27 ++
 rtl/iq_sat_accum.sv | 81 ++++++++
 2 files changed

// File: rtl/iq_sat_accum_if.sv
// iq_sat_accum_if: sample/result bus for iq_sat_accum
//   master drives in_valid, i, q, mode, clr_stats; slave drives out_valid, sum, sat, sat_count
interface iq_sat_accum_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [IN_W-1:0]  i;
    logic [IN_W-1:0]  q;
    logic [1:0]       mode;
    logic             clr_stats;
    logic             out_valid;
    logic [OUT_W-1:0] sum;
    logic             sat;
    logic [CNT_W-1:0] sat_count;

    modport master (
        output in_valid, i, q, mode, clr_stats,
        input  out_valid, sum, sat, sat_count
    );

    modport slave (
        input  in_valid, i, q, mode, clr_stats,
        output out_valid, sum, sat, sat_count
    );
endinterface

// File: rtl/iq_sat_accum.sv
// iq_sat_accum: saturating I/Q combiner with ADD/SUB/ACC modes and saturation statistics
//   M100CLK  system clock, rising edge
//   reset    synchronous active-high reset
//   bus      slave side: in_valid/i/q/mode/clr_stats in, out_valid/sum/sat/sat_count out
module iq_sat_accum #(
    parameter int IN_W    = 32,
    parameter int OUT_W   = 32,
    parameter int ACC_LEN = 16,
    parameter int CNT_W   = 16
) (
    input logic          M100CLK,
    input logic          reset,
    iq_sat_accum_if.slave bus
);
    localparam int CW = $clog2(ACC_LEN);
    localparam int AW = IN_W + 1 + CW;
    localparam logic [CW-1:0] LAST  = CW'(ACC_LEN - 1);
    localparam logic [AW-1:0] MAX_V = {{(AW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic [AW-1:0] MIN_V = ~MAX_V;

    logic             v1_q, v1_d, acc1_q, acc1_d;
    logic [IN_W:0]    raw_q, raw_d;
    logic [AW-1:0]    acc_q, acc_d, raw_x, acc_sum, res;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d, sat_q, sat_d;
    logic             last, emit, hi, lo;
    logic [OUT_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] sat_count_q, sat_count_d;

    always_comb begin
        v1_d        = bus.in_valid;
        acc1_d      = bus.in_valid ? bus.mode == 2'b10 : acc1_q;
        raw_d       = !bus.in_valid ? raw_q :
                      bus.mode == 2'b01 ? {bus.i[IN_W-1], bus.i} - {bus.q[IN_W-1], bus.q} :
                                          {bus.i[IN_W-1], bus.i} + {bus.q[IN_W-1], bus.q};
        raw_x       = {{CW{raw_q[IN_W]}}, raw_q};
        acc_sum     = acc_q + raw_x;
        last        = acc1_q && cnt_q == LAST;
        // a non-ACC sample is always output and also drops any partial frame
        emit        = v1_q && (!acc1_q || last);
        res         = acc1_q ? acc_sum : raw_x;
        hi          = $signed(res) > $signed(MAX_V);
        lo          = $signed(res) < $signed(MIN_V);
        acc_d       = (v1_q && acc1_q && !last) ? (cnt_q == '0 ? raw_x : acc_sum) : acc_q;
        cnt_d       = !v1_q ? cnt_q : emit ? '0 : cnt_q + 1'b1;
        out_valid_d = emit;
        sat_d       = emit && (hi || lo);
        sum_d       = !emit ? sum_q : hi ? MAX_V[OUT_W-1:0] : lo ? MIN_V[OUT_W-1:0] : res[OUT_W-1:0];
        sat_count_d = bus.clr_stats ? '0 :
                      (sat_d && !(&sat_count_q)) ? sat_count_q + 1'b1 : sat_count_q;
    end

    always_ff @(posedge M100CLK) begin
        if (reset) begin
            v1_q        <= 1'b0;
            acc1_q      <= 1'b0;
            raw_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            sum_q       <= '0;
            sat_count_q <= '0;
        end else begin
            v1_q        <= v1_d;
            acc1_q      <= acc1_d;
            raw_q       <= raw_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
            sum_q       <= sum_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.sat       = sat_q;
    assign bus.sat_count = sat_count_q;
endmodule
